// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: datapath width, opcodes,
// FSM state encoding and flag bit positions.
package alu_pkg;

   localparam int ALU_WIDTH = 16;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;
   localparam logic [3:0] OP_DIV  = 4'd9;
   localparam logic [3:0] OP_PASS = 4'd10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ITER = 1'b1
   } state_t;

   localparam int FLAG_V = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 3;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned MUL (right-shifting shift-add) and DIV (restoring) datapath.
// lo/hi present the partial state as it will be after the step now in progress.
module alu_iter_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic [WIDTH-1:0] opd_r;
   logic [WIDTH:0]   mul_sum_s;
   logic [WIDTH:0]   div_sh_s;
   logic [WIDTH:0]   div_diff_s;

   // Next partial product / remainder:quotient for one iteration
   always_comb begin
      mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
      div_sh_s   = {hi_r, lo_r[WIDTH-1]};
      div_diff_s = div_sh_s - {1'b0, opd_r};
      if (is_div) begin
         // A set top bit means the trial subtraction went negative: restore
         if (!div_diff_s[WIDTH]) begin
            hi = div_diff_s[WIDTH-1:0];
            lo = {lo_r[WIDTH-2:0], 1'b1};
         end else begin
            hi = div_sh_s[WIDTH-1:0];
            lo = {lo_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi = mul_sum_s[WIDTH:1];
         lo = {mul_sum_s[0], lo_r[WIDTH-1:1]};
      end
   end

   // Operand capture and per-edge iteration state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_r  <= {WIDTH{1'b0}};
         lo_r  <= {WIDTH{1'b0}};
         opd_r <= {WIDTH{1'b0}};
      end else if (load) begin
         hi_r  <= {WIDTH{1'b0}};
         lo_r  <= a;
         opd_r <= b;
      end else if (step) begin
         hi_r  <= hi;
         lo_r  <= lo;
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Sequential ALU feeding the accumulator: single-cycle ops complete on the start
// edge, MUL/DIV iterate WIDTH edges behind a busy/done handshake.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic [3:0]       flags,
   output logic             busy,
   output logic             done,
   output logic             acc_we
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state_r;
   logic [CW-1:0]    cnt_r;
   logic             div_r;
   logic             load_s;
   logic             step_s;
   logic [WIDTH-1:0] iter_lo_s;
   logic [WIDTH-1:0] iter_hi_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   shl_s;
   logic [WIDTH:0]   shr_s;
   logic [WIDTH-1:0] alu_res_s;
   logic             alu_c_s;
   logic             alu_v_s;

   function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                             input logic c, input logic v);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_Z] = (r == {WIDTH{1'b0}});
      f[FLAG_N] = r[WIDTH-1];
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

   alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .reset  (reset),
      .load   (load_s),
      .step   (step_s),
      .is_div (div_r),
      .a      (a),
      .b      (b),
      .lo     (iter_lo_s),
      .hi     (iter_hi_s)
   );

   // Iteration datapath control
   always_comb begin
      if (state_r == ST_IDLE) begin
         load_s = start && ((op == OP_MUL) || ((op == OP_DIV) && (b != {WIDTH{1'b0}})));
         step_s = 1'b0;
      end else begin
         load_s = 1'b0;
         step_s = 1'b1;
      end
   end

   // Single-cycle result and carry/overflow
   always_comb begin
      sum_s     = {(WIDTH+1){1'b0}};
      shl_s     = {1'b0, a} << b[3:0];
      shr_s     = {a, 1'b0} >> b[3:0];
      alu_res_s = {WIDTH{1'b0}};
      alu_c_s   = 1'b0;
      alu_v_s   = 1'b0;
      case (op)
         OP_ADD: begin
            sum_s     = {1'b0, a} + {1'b0, b};
            alu_res_s = sum_s[WIDTH-1:0];
            alu_c_s   = sum_s[WIDTH];
            alu_v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            sum_s     = {1'b0, a} - {1'b0, b};
            alu_res_s = sum_s[WIDTH-1:0];
            alu_c_s   = sum_s[WIDTH];
            alu_v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_res_s = a & b;
         OP_OR:   alu_res_s = a | b;
         OP_XOR:  alu_res_s = a ^ b;
         OP_NOT:  alu_res_s = ~a;
         // Extra guard bit catches the last bit shifted out (zero for amount 0)
         OP_SHL: begin
            alu_res_s = shl_s[WIDTH-1:0];
            alu_c_s   = shl_s[WIDTH];
         end
         OP_SHR: begin
            alu_res_s = shr_s[WIDTH:1];
            alu_c_s   = shr_s[0];
         end
         OP_PASS: alu_res_s = b;
         default: alu_res_s = {WIDTH{1'b0}};
      endcase
   end

   // Control FSM with registered result, flags and handshake
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CW{1'b0}};
         div_r   <= 1'b0;
         result  <= {WIDTH{1'b0}};
         hi      <= {WIDTH{1'b0}};
         flags   <= 4'b0000;
         busy    <= 1'b0;
         done    <= 1'b0;
         acc_we  <= 1'b0;
      end else begin
         done   <= 1'b0;
         acc_we <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  if (load_s) begin
                     state_r <= ST_ITER;
                     cnt_r   <= {CW{1'b0}};
                     div_r   <= (op == OP_DIV);
                     busy    <= 1'b1;
                  end else if (op == OP_DIV) begin
                     result <= {WIDTH{1'b1}};
                     hi     <= a;
                     flags  <= pack_flags({WIDTH{1'b1}}, 1'b0, 1'b1);
                     done   <= 1'b1;
                     acc_we <= 1'b1;
                  end else if (op > OP_PASS) begin
                     done   <= 1'b1;
                  end else begin
                     result <= alu_res_s;
                     hi     <= {WIDTH{1'b0}};
                     flags  <= pack_flags(alu_res_s, alu_c_s, alu_v_s);
                     done   <= 1'b1;
                     acc_we <= 1'b1;
                  end
               end
            end
            ST_ITER: begin
               cnt_r <= cnt_r + CW'(1);
               if (cnt_r == CNT_LAST) begin
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  acc_we  <= 1'b1;
                  result  <= iter_lo_s;
                  hi      <= iter_hi_s;
                  if (div_r) begin
                     flags <= pack_flags(iter_lo_s, 1'b0, 1'b0);
                  end else begin
                     flags <= pack_flags(iter_lo_s, iter_hi_s != {WIDTH{1'b0}},
                                         iter_hi_s != {WIDTH{1'b0}});
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
